// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encodings and frame constants for the program loader
package loader_pkg;

   typedef enum logic [2:0] {
      S_MAGIC = 3'd0,
      S_LEN   = 3'd1,
      S_LOAD  = 3'd2,
      S_CSUM  = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } loader_state_e;

   localparam logic [31:0] MAGIC_DEFAULT = 32'h4D495053;

endpackage

// File: rtl/loader_csum.sv
// rtl/loader_csum.sv - 32-bit clear/accumulate/compare unit for payload checksums
module loader_csum (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        acc_en,
   input  logic [31:0] din,
   input  logic [31:0] cmp_word,
   output logic        match
);

   logic [31:0] sum_q;
   logic [31:0] sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr) begin
         sum_d = '0;
      end else if (acc_en) begin
         sum_d = sum_q + din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign match = (sum_q == cmp_word);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - parses magic/length/payload frames into imem and gates core reset
// Optional trailing checksum word enabled by defining LOADER_CSUM_EN.
module prog_loader
   import loader_pkg::*;
#(
   parameter int          ADDR_W = 10,
   parameter logic [31:0] MAGIC  = MAGIC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       in_word,
   input  logic              in_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [31:0] CAP = 32'(1) << ADDR_W;

   loader_state_e     state_q, state_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;

`ifdef LOADER_CSUM_EN
   logic csum_clr;
   logic csum_acc;
   logic csum_match;

   loader_csum u_csum (
      .clk      (clk),
      .rst      (rst),
      .clr      (csum_clr),
      .acc_en   (csum_acc),
      .din      (in_word),
      .cmp_word (in_word),
      .match    (csum_match)
   );
`endif

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
`ifdef LOADER_CSUM_EN
      csum_clr = 1'b0;
      csum_acc = 1'b0;
`endif
      if (in_valid) begin
         case (state_q)
            S_MAGIC: begin
               // Non-magic words are silently dropped so the loader resyncs on garbage.
               if (in_word == MAGIC) begin
                  state_d = S_LEN;
`ifdef LOADER_CSUM_EN
                  csum_clr = 1'b1;
`endif
               end
            end
            S_LEN: begin
               if (in_word == 32'd0 || in_word > CAP) begin
                  state_d = S_ERR;
               end else begin
                  rem_d   = in_word[ADDR_W:0];
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               we_d    = 1'b1;
               wdata_d = in_word;
               addr_d  = idx_q;
               idx_d   = idx_q + ADDR_W'(1);
               rem_d   = rem_q - (ADDR_W+1)'(1);
`ifdef LOADER_CSUM_EN
               csum_acc = 1'b1;
`endif
               if (rem_q == (ADDR_W+1)'(1)) begin
`ifdef LOADER_CSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               end
            end
            S_CSUM: begin
`ifdef LOADER_CSUM_EN
               state_d = csum_match ? S_DONE : S_ERR;
`else
               state_d = S_ERR;
`endif
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_MAGIC;
         rem_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_rst_n  = (state_q == S_DONE);
   assign busy       = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_CSUM);
   assign done       = (state_q == S_DONE);
   assign err        = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

   localparam int          ADDR_W = 10;
   localparam logic [31:0] MAGIC  = 32'h4D495053;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [31:0]       in_word = '0;
   logic              in_valid = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst_n;
   logic              busy;
   logic              done;
   logic              err;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W-1:0] wa[$];
   logic [31:0]       wd[$];

   always #5 clk = ~clk;

   prog_loader #(.ADDR_W(ADDR_W), .MAGIC(MAGIC)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_word    (in_word),
      .in_valid   (in_valid),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Log every write-enable cycle shortly after the edge that produced it.
   always @(posedge clk) begin
      #1;
      if (rst && imem_we) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_wdata);
      end
   end

   task automatic send(input logic [31:0] w);
      @(negedge clk);
      in_word  = w;
      in_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_word  = '0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      in_word  = '0;
      @(negedge clk);
      rst = 1'b1;
      wa.delete();
      wd.delete();
   endtask

   task automatic send_frame3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      send(MAGIC);
      send(32'd3);
      send(a);
      send(b);
      send(c);
`ifdef LOADER_CSUM_EN
      send(a + b + c);
`endif
      idle(1);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", imem_we); end
      checks++; if (imem_addr !== '0) begin errors++; $display("FAIL reset_addr got %0h want 0", imem_addr); end
      checks++; if (imem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %0h want 0", imem_wdata); end
      checks++; if ({cpu_rst_n, busy, done, err} !== 4'b0000) begin errors++;
         $display("FAIL reset_flags got %b want 0000", {cpu_rst_n, busy, done, err}); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      send(MAGIC);
      send(32'd3);
      send(32'h11111111);
      checks++; if ({busy, done, cpu_rst_n} !== 3'b100) begin errors++;
         $display("FAIL basic_busy got %b want 100", {busy, done, cpu_rst_n}); end
      send(32'h22222222);
      send(32'h33333333);
`ifdef LOADER_CSUM_EN
      send(32'h66666666);
`endif
      idle(1);
      checks++; if ({done, cpu_rst_n, busy, err} !== 4'b1100) begin errors++;
         $display("FAIL basic_done got %b want 1100", {done, cpu_rst_n, busy, err}); end
`ifndef LOADER_CSUM_EN
      checks++; if (imem_we !== 1'b1 || imem_addr !== 10'h002) begin errors++;
         $display("FAIL basic_last_we got we=%0b addr=%0h want we=1 addr=2", imem_we, imem_addr); end
`endif
      idle(2);
      checks++; if (wa.size() != 3) begin errors++; $display("FAIL basic_count got %0d want 3", wa.size()); end
      else begin
         checks++; if (wa[0] !== 10'd0 || wa[1] !== 10'd1 || wa[2] !== 10'd2) begin errors++;
            $display("FAIL basic_addr got %0h %0h %0h want 0 1 2", wa[0], wa[1], wa[2]); end
         checks++; if (wd[0] !== 32'h11111111 || wd[1] !== 32'h22222222 || wd[2] !== 32'h33333333) begin errors++;
            $display("FAIL basic_data got %h %h %h want 11111111 22222222 33333333", wd[0], wd[1], wd[2]); end
      end
   endtask

   task automatic test_resync();
      do_reset();
      send(32'hDEADBEEF);
      idle(1);
      checks++; if ({busy, err, done} !== 3'b000) begin errors++;
         $display("FAIL resync_idle got %b want 000", {busy, err, done}); end
      send_frame3(32'h11111111, 32'h22222222, 32'h33333333);
      idle(1);
      checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++;
         $display("FAIL resync_done got done=%0b err=%0b want 1 0", done, err); end
      checks++; if (wa.size() != 3) begin errors++; $display("FAIL resync_count got %0d want 3", wa.size()); end
      else begin
         checks++; if (wa[0] !== 10'd0 || wa[2] !== 10'd2 || wd[0] !== 32'h11111111 || wd[2] !== 32'h33333333) begin
            errors++; $display("FAIL resync_data got %0h:%h %0h:%h", wa[0], wd[0], wa[2], wd[2]); end
      end
   endtask

   task automatic test_bad_len();
      do_reset();
      send(MAGIC);
      send(32'd0);
      idle(1);
      checks++; if ({err, cpu_rst_n, busy, done} !== 4'b1000) begin errors++;
         $display("FAIL len0_err got %b want 1000", {err, cpu_rst_n, busy, done}); end
      send(MAGIC);
      send(32'd1);
      send(32'h12345678);
      idle(2);
      checks++; if (err !== 1'b1 || wa.size() != 0) begin errors++;
         $display("FAIL len0_sticky got err=%0b writes=%0d want 1 0", err, wa.size()); end
      do_reset();
      send(MAGIC);
      send(32'd1025);
      send(32'h00000001);
      idle(2);
      checks++; if ({err, cpu_rst_n} !== 2'b10 || wa.size() != 0) begin errors++;
         $display("FAIL len1025_err got err/rstn=%b writes=%0d want 10 0", {err, cpu_rst_n}, wa.size()); end
   endtask

   task automatic test_full();
      logic [31:0] sum;
      int bad;
      sum = '0;
      bad = 0;
      do_reset();
      send(MAGIC);
      send(32'd1024);
      for (int i = 0; i < 1024; i++) begin
         send(32'hC0DE0000 | 32'(i));
         sum = sum + (32'hC0DE0000 | 32'(i));
         if (i % 4 == 3) idle(1);
      end
`ifdef LOADER_CSUM_EN
      send(sum);
`endif
      idle(2);
      checks++; if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin errors++;
         $display("FAIL full_done got done=%0b rstn=%0b want 1 1", done, cpu_rst_n); end
      checks++; if (wa.size() != 1024) begin errors++; $display("FAIL full_count got %0d want 1024", wa.size()); end
      else begin
         checks++; if (wa[1023] !== 10'h3FF) begin errors++; $display("FAIL full_last_addr got %0h want 3ff", wa[1023]); end
         for (int i = 0; i < 1024; i++) begin
            if (wa[i] !== 10'(i) || wd[i] !== (32'hC0DE0000 | 32'(i))) bad++;
         end
         checks++; if (bad != 0) begin errors++; $display("FAIL full_contents got %0d bad entries want 0", bad); end
      end
      send(MAGIC);
      send(32'd1);
      send(32'h0BADF00D);
      idle(2);
      checks++; if (wa.size() != 1024 || done !== 1'b1) begin errors++;
         $display("FAIL full_after_done got writes=%0d done=%0b want 1024 1", wa.size(), done); end
   endtask

`ifdef LOADER_CSUM_EN
   task automatic test_csum();
      do_reset();
      send(MAGIC);
      send(32'd3);
      send(32'd1);
      send(32'd2);
      send(32'd3);
      idle(1);
      checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL csum_wait got %b want 10", {busy, done}); end
      send(32'd6);
      idle(1);
      checks++; if ({done, cpu_rst_n, err} !== 3'b110) begin errors++;
         $display("FAIL csum_ok got %b want 110", {done, cpu_rst_n, err}); end
      do_reset();
      send(MAGIC);
      send(32'd3);
      send(32'd1);
      send(32'd2);
      send(32'd3);
      send(32'd7);
      idle(1);
      checks++; if ({err, cpu_rst_n, done} !== 3'b100) begin errors++;
         $display("FAIL csum_bad got %b want 100", {err, cpu_rst_n, done}); end
   endtask
`endif

   task automatic test_mid_reset();
      do_reset();
      send(MAGIC);
      send(32'd3);
      send(32'hAAAA0001);
      send(32'hAAAA0002);
      @(posedge clk);
      #2;
      checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL midrst_pre_we got %0b want 1", imem_we); end
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++; if ({imem_we, cpu_rst_n, busy, done, err} !== 5'b00000 || imem_addr !== '0 || imem_wdata !== 32'd0) begin
         errors++; $display("FAIL midrst_values got flags=%b addr=%0h wdata=%h want 00000 0 0",
            {imem_we, cpu_rst_n, busy, done, err}, imem_addr, imem_wdata); end
      @(negedge clk);
      rst = 1'b1;
      wa.delete();
      wd.delete();
      send_frame3(32'hBBBB0000, 32'hBBBB0001, 32'hBBBB0002);
      idle(1);
      checks++; if (done !== 1'b1 || wa.size() != 3) begin errors++;
         $display("FAIL midrst_reload got done=%0b writes=%0d want 1 3", done, wa.size()); end
      else begin
         checks++; if (wa[0] !== 10'd0 || wd[0] !== 32'hBBBB0000 || wa[2] !== 10'd2 || wd[2] !== 32'hBBBB0002) begin
            errors++; $display("FAIL midrst_data got %0h:%h %0h:%h", wa[0], wd[0], wa[2], wd[2]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_resync();
      test_bad_len();
      test_full();
`ifdef LOADER_CSUM_EN
      test_csum();
`endif
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
